spi_flash_frame_loader: RTL and testbench

- Boot/refresh loader for the 12bpp LED panel datapath.
- On `start`, reads one packed frame from SPI flash: a 0xFF recovery preamble, then READ (03h) from `base_addr`.
- Converts each byte pair into one RGB444 pixel and writes it sequentially into the panel framebuffer write port.
- Sits upstream of the framebuffer/scan driver and replaces the diagnostic-only flash reader in the production path.

---
 rtl/flash_loader_pkg.sv | 24 ++
 rtl/spi_shift_engine.sv | 91 +++++++++
 rtl/spi_flash_frame_loader.sv | 198 +++++++++++++++++++
 tb/tb_spi_flash_frame_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI flash frame loader: FSM encoding,
// flash opcodes and the byte-pair to RGB444 packing rule.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_GAP,
    ST_CMD,
    ST_RD_HI,
    ST_RD_LO,
    ST_WR,
    ST_FIN
  } state_e;

  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_RELEASE = 8'hFF;

  // The low nibble of the second byte is padding in the packed frame format.
  function automatic logic [11:0] pack_rgb444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo[7:4]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shifter: SCK_HALF clock divider plus an 8/32-bit MSB-first
// transmit/receive shift register. Optional tail keeps the clock low for one
// extra half period after the last falling edge so CS may rise safely.
module spi_shift_engine #(
  parameter int SCK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        len32_i,
  input  logic        tail_i,
  input  logic [31:0] tx_data_i,
  input  logic        miso_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic [7:0]  rx_byte_o
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic          busy_q;
  logic          sclk_q;
  logic          tail_q;
  logic          in_tail_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    bits_q;
  logic [31:0]   tx_q;
  logic [7:0]    rx_q;
  logic          tick;

  assign tick = busy_q && (cnt_q == CW'(SCK_HALF - 1));

  // Done is combinational so the caller can chain the next transfer on the
  // very edge this one ends, keeping back-to-back bytes gap-free.
  assign done_o    = tick && (in_tail_q || (sclk_q && (bits_q == 6'd1) && !tail_q));
  assign busy_o    = busy_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[31];
  assign rx_byte_o = rx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      tail_q    <= 1'b0;
      in_tail_q <= 1'b0;
      cnt_q     <= '0;
      bits_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else if (abort_i) begin
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      in_tail_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start_i) begin
      busy_q    <= 1'b1;
      sclk_q    <= 1'b0;
      tail_q    <= tail_i;
      in_tail_q <= 1'b0;
      cnt_q     <= '0;
      bits_q    <= len32_i ? 6'd32 : 6'd8;
      tx_q      <= len32_i ? tx_data_i : {tx_data_i[7:0], 24'h0};
    end else if (busy_q) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        if (in_tail_q) begin
          busy_q    <= 1'b0;
          in_tail_q <= 1'b0;
        end else if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          tx_q   <= {tx_q[30:0], 1'b0};
          bits_q <= bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            if (tail_q) in_tail_q <= 1'b1;
            else        busy_q    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_frame_loader.sv
// Loads one RGB444 frame from SPI flash into the panel framebuffer.
// Define FLASH_LOADER_CKSUM_EN to add the 16-bit raw-byte checksum output.
module spi_flash_frame_loader
  import flash_loader_pkg::*;
#(
  parameter int PIXELS       = 2048,
  parameter int FB_AW        = 11,
  parameter int SCK_HALF     = 2,
  parameter int RECOV_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [23:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic             spi_cs,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [11:0]      fb_wdata
`ifdef FLASH_LOADER_CKSUM_EN
  ,
  output logic [15:0]      cksum
`endif
);

  localparam int GW = $clog2(RECOV_CYCLES + 1);

  state_e           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [FB_AW-1:0] pix_q, pix_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [11:0]      wdata_q, wdata_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic        eng_start, eng_abort, eng_len32, eng_tail;
  logic [31:0] eng_tx;
  logic        eng_busy, eng_done, eng_sclk, eng_mosi;
  logic [7:0]  eng_rx;

`ifdef FLASH_LOADER_CKSUM_EN
  logic [15:0] sum_q, sum_d;
  assign cksum = sum_q;
`endif

  spi_shift_engine #(.SCK_HALF(SCK_HALF)) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start_i   (eng_start),
    .abort_i   (eng_abort),
    .len32_i   (eng_len32),
    .tail_i    (eng_tail),
    .tx_data_i (eng_tx),
    .miso_i    (spi_miso),
    .busy_o    (eng_busy),
    .done_o    (eng_done),
    .sclk_o    (eng_sclk),
    .mosi_o    (eng_mosi),
    .rx_byte_o (eng_rx)
  );

  assign eng_abort = abort && (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
      byte0_q <= '0;
      wdata_q <= '0;
      gap_q   <= '0;
`ifdef FLASH_LOADER_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      byte0_q <= byte0_d;
      wdata_q <= wdata_d;
      gap_q   <= gap_d;
`ifdef FLASH_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pix_d     = pix_q;
    byte0_d   = byte0_q;
    wdata_d   = wdata_q;
    gap_d     = gap_q;
    eng_start = 1'b0;
    eng_len32 = 1'b0;
    eng_tail  = 1'b0;
    eng_tx    = '0;
`ifdef FLASH_LOADER_CKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          addr_d    = base_addr;
          pix_d     = '0;
          eng_start = 1'b1;
          eng_tail  = 1'b1;
          eng_tx    = {24'h0, CMD_RELEASE};
          state_d   = ST_PRE;
`ifdef FLASH_LOADER_CKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      ST_PRE: begin
        if (eng_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(RECOV_CYCLES - 1)) begin
          eng_start = 1'b1;
          eng_len32 = 1'b1;
          eng_tx    = {CMD_READ, addr_q};
          state_d   = ST_CMD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_CMD: begin
        if (eng_done) begin
          eng_start = 1'b1;
          state_d   = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        if (eng_done) begin
          byte0_d   = eng_rx;
          eng_start = 1'b1;
          // The last byte of the frame needs a trailing low half before CS rises.
          eng_tail  = (pix_q == FB_AW'(PIXELS - 1));
          state_d   = ST_RD_LO;
`ifdef FLASH_LOADER_CKSUM_EN
          sum_d     = sum_q + {8'h0, eng_rx};
`endif
        end
      end
      ST_RD_LO: begin
        if (eng_done) begin
          wdata_d = pack_rgb444(byte0_q, eng_rx);
          state_d = ST_WR;
`ifdef FLASH_LOADER_CKSUM_EN
          sum_d   = sum_q + {8'h0, eng_rx};
`endif
        end
      end
      ST_WR: begin
        if (pix_q == FB_AW'(PIXELS - 1)) begin
          state_d = ST_FIN;
        end else begin
          pix_d     = pix_q + FB_AW'(1);
          eng_start = 1'b1;
          state_d   = ST_RD_HI;
        end
      end
      ST_FIN: begin
        pix_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (eng_abort) begin
      eng_start = 1'b0;
      pix_d     = '0;
      state_d   = ST_IDLE;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign fb_we    = (state_q == ST_WR);
  assign fb_addr  = pix_q;
  assign fb_wdata = wdata_q;
  assign spi_cs   = !(state_q inside {ST_PRE, ST_CMD, ST_RD_HI, ST_RD_LO, ST_WR});
  assign spi_clk  = eng_sclk;
  assign spi_mosi = eng_busy & eng_mosi;

endmodule

// File: tb/tb_spi_flash_frame_loader.sv
// Self-checking bench: table vectors, random frames against a byte-level
// flash/frame model, abort, start-noise, start+abort and async reset cases.
module tb_spi_flash_frame_loader;

  localparam int PIXELS       = 16;
  localparam int FB_AW        = 4;
  localparam int SCK_HALF     = 2;
  localparam int RECOV_CYCLES = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [23:0]      base_addr = '0;
  logic             spi_miso = 1'b0;
  logic             busy, done, spi_cs, spi_clk, spi_mosi, fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [11:0]      fb_wdata;
`ifdef FLASH_LOADER_CKSUM_EN
  logic [15:0]      cksum;
  logic [15:0]      done_cksum;
`endif

  spi_flash_frame_loader #(
    .PIXELS(PIXELS), .FB_AW(FB_AW), .SCK_HALF(SCK_HALF), .RECOV_CYCLES(RECOV_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .busy(busy), .done(done), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata)
`ifdef FLASH_LOADER_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- flash model: byte array + READ streaming ----------------
  logic [7:0] mem [int];
  int          nbits;
  logic [31:0] hdr;
  int          sess_bits[$];
  logic [31:0] sess_hdr[$];

  function automatic logic [7:0] flash_rd(input int a);
    int aa;
    aa = a & 32'h00FF_FFFF;
    if (mem.exists(aa)) return mem[aa];
    return 8'(aa * 7) ^ 8'h5A;
  endfunction

  always @(negedge spi_cs) begin
    nbits = 0;
    hdr   = '0;
  end

  always @(posedge spi_cs) begin
    if (nbits > 0) begin
      sess_bits.push_back(nbits);
      sess_hdr.push_back(hdr);
    end
  end

  always @(posedge spi_clk) begin
    if (!spi_cs) begin
      if (nbits < 32) hdr = {hdr[30:0], spi_mosi};
      nbits++;
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_cs && nbits >= 32 && hdr[31:24] == 8'h03) begin
      int k;
      logic [7:0] b;
      k = nbits - 32;
      b = flash_rd(int'(hdr[23:0]) + k / 8);
      spi_miso = b[7 - (k % 8)];
    end
  end

  // ---------------- output monitors (sampled on falling clk) ----------------
  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t  wr_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   first_we_cyc = -1;
  int   viol = 0;
  bit   tmon_en = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_sck = 1'b0;
  int   t_csfall = 0;
  int   t_fall = 0;
  bit   rose_in = 1'b0;
  bit   fell_in = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (fb_we === 1'b1) begin
      wr_q.push_back('{int'(fb_addr), int'(fb_wdata)});
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
`ifdef FLASH_LOADER_CKSUM_EN
      done_cksum = cksum;
`endif
    end
    if (tmon_en && !rst) begin
      if (prev_cs && !spi_cs) begin
        t_csfall = cyc;
        rose_in  = 1'b0;
        fell_in  = 1'b0;
      end
      if (!prev_sck && spi_clk) begin
        if (spi_cs) viol++;
        else if (!rose_in && (cyc - t_csfall) < SCK_HALF) viol++;
        rose_in = 1'b1;
      end
      if (prev_sck && !spi_clk) begin
        t_fall  = cyc;
        fell_in = 1'b1;
      end
      if (!prev_cs && spi_cs && fell_in && (cyc - t_fall) < SCK_HALF) viol++;
    end
    prev_cs  = spi_cs;
    prev_sck = spi_clk;
  end

  // ---------------- helpers ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"},    spi_cs,   1'b1);
    check({tag, "_sck"},   spi_clk,  1'b0);
    check({tag, "_mosi"},  spi_mosi, 1'b0);
    check({tag, "_busy"},  busy,     1'b0);
    check({tag, "_done"},  done,     1'b0);
    check({tag, "_we"},    fb_we,    1'b0);
    check({tag, "_addr"},  fb_addr,  '0);
  endtask

  task automatic preload(input logic [23:0] base);
    mem.delete();
    for (int i = 0; i < 2 * PIXELS; i++) mem[int'(base + 24'(i))] = 8'($urandom);
  endtask

  task automatic clear_monitors();
    wr_q.delete();
    sess_bits.delete();
    sess_hdr.delete();
    done_cnt     = 0;
    first_we_cyc = -1;
    viol         = 0;
  endtask

  // One complete load checked against the frame model.
  task automatic do_load(input logic [23:0] base, input bit noisy, input string tag);
    int t0, lat, lo;
    logic [7:0]  hb, lb;
    logic [15:0] sum;
    clear_monitors();
    tmon_en = 1'b1;
    @(negedge clk); #1;
    start = 1'b1;
    base_addr = base;
    t0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    base_addr = 24'($urandom);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
      start = noisy && (i % 50 == 7);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done_cnt, 1);
    @(negedge clk);
    check({tag, "_busy_after_done"}, busy, 1'b0);
    check({tag, "_addr_after_done"}, fb_addr, '0);
    repeat (8) @(negedge clk);
    check({tag, "_single_done"}, done_cnt, 1);
    check({tag, "_still_idle"}, busy, 1'b0);
    check({tag, "_we_count"}, wr_q.size(), PIXELS);
    sum = '0;
    for (int i = 0; i < PIXELS; i++) begin
      hb = flash_rd(int'(base) + 2 * i);
      lb = flash_rd(int'(base) + 2 * i + 1);
      sum = sum + 16'(hb) + 16'(lb);
      if (i < wr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
        check($sformatf("%s_pix%0d", tag, i), wr_q[i].data, {hb, lb[7:4]});
      end
    end
    lat = first_we_cyc - t0;
    lo  = 1 + 16 * SCK_HALF + RECOV_CYCLES + 96 * SCK_HALF;
    check({tag, "_latency_ok"}, (lat >= lo) && (lat <= lo + 8), 1'b1);
    check({tag, "_cs_timing_viol"}, viol, 0);
    check({tag, "_sessions"}, sess_bits.size(), 2);
    if (sess_bits.size() == 2) begin
      check({tag, "_pre_bits"}, sess_bits[0], 8);
      check({tag, "_pre_byte"}, sess_hdr[0], 32'h0000_00FF);
      check({tag, "_rd_hdr"}, sess_hdr[1], {8'h03, base});
      check({tag, "_rd_bits"}, sess_bits[1], 32 + 16 * PIXELS);
    end
`ifdef FLASH_LOADER_CKSUM_EN
    check({tag, "_cksum"}, done_cksum, sum);
`endif
  endtask

  task automatic wait_cycles_after_start(input logic [23:0] base, input int n);
    @(negedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [23:0] base;
    logic [7:0]  b0, b1, b2, b3;
    logic [11:0] px0, px1;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{24'h010000, 8'hA5, 8'h3C, 8'h12, 8'hF0, 12'hA53, 12'h12F};
    vecs[1] = '{24'h7FFFF0, 8'h00, 8'hFF, 8'h0F, 8'h81, 12'h00F, 12'h0F8};
    vecs[2] = '{24'hFFFFF0, 8'h5A, 8'hC3, 8'hE7, 8'h19, 12'h5AC, 12'hE71};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_wdata", fb_wdata, 12'h000);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      preload(vecs[v].base);
      mem[int'(vecs[v].base)]          = vecs[v].b0;
      mem[int'(vecs[v].base + 24'd1)]  = vecs[v].b1;
      mem[int'(vecs[v].base + 24'd2)]  = vecs[v].b2;
      mem[int'(vecs[v].base + 24'd3)]  = vecs[v].b3;
      do_load(vecs[v].base, 1'b0, $sformatf("vec%0d", v));
      if (wr_q.size() >= 2) begin
        check($sformatf("vec%0d_px0_const", v), wr_q[0].data, vecs[v].px0);
        check($sformatf("vec%0d_px1_const", v), wr_q[1].data, vecs[v].px1);
      end else begin
        check($sformatf("vec%0d_px_present", v), wr_q.size(), 2);
      end
    end

    for (int r = 0; r < 3; r++) begin
      logic [23:0] b;
      b = 24'($urandom);
      preload(b);
      do_load(b, 1'b0, $sformatf("rand%0d", r));
    end

    // start pulsed repeatedly while busy
    preload(24'h123456);
    do_load(24'h123456, 1'b1, "noisy");

    // abort in the middle of pixel 5
    preload(24'h020000);
    clear_monitors();
    tmon_en = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    base_addr = 24'h020000;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6000 && wr_q.size() < 5; i++) @(negedge clk);
    check("abort_reached_px5", wr_q.size(), 5);
    repeat (20) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_cs", spi_cs, 1'b1);
    check("abort_sck", spi_clk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_we", fb_we, 1'b0);
    #1 abort = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_more_we", wr_q.size(), 5);
    check("abort_no_done", done_cnt, 0);
    do_load(24'h020000, 1'b0, "post_abort");

    // start and abort together in IDLE
    clear_monitors();
    @(negedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 1'b0);
    check("sa_cs", spi_cs, 1'b1);
    repeat (100) @(negedge clk);
    check("sa_no_session", sess_bits.size(), 0);
    check("sa_no_we", wr_q.size(), 0);

    // asynchronous reset in the middle of the READ command
    preload(24'h0ABCDE);
    tmon_en = 1'b0;
    wait_cycles_after_start(24'h0ABCDE, 17 * SCK_HALF + RECOV_CYCLES + 40);
    check("pre_rst_in_cmd_cs", spi_cs, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    do_load(24'h0ABCDE, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
